// File: rtl/gps_time_conv.sv
// GPS UTC time converter.
// Reads the six ASCII characters "hhmmss" from the GPS RAM through its
// one-cycle synchronous read port. Validates them, applies a whole-hour
// local offset and presents BCD digits with done/err status pulses.
module gps_time_conv #(
   parameter int UTC_OFFSET = 8,
   parameter int BASE_ADDR  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       gps_valid,
   output logic [5:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [3:0] hh_t,
   output logic [3:0] hh_o,
   output logic [3:0] mm_t,
   output logic [3:0] mm_o,
   output logic [3:0] ss_t,
   output logic [3:0] ss_o,
   output logic       time_valid
);

   localparam logic [5:0] ADDR_FIRST = 6'(BASE_ADDR);
   localparam logic [5:0] ADDR_LAST  = ADDR_FIRST + 6'd5;
   localparam logic [5:0] OFFSET     = 6'(UTC_OFFSET);

   typedef enum logic [1:0] {IDLE, READ, CALC, FIN} state_t;

   state_t      state_reg, state_next;
   logic [2:0]  cnt_reg;
   logic [7:0]  byte_reg [6];
   logic [3:0]  dig [6];
   logic [5:0]  char_ok;
   logic        accept;
   logic        fields_ok;
   logic        conv_ok;
   logic [5:0]  hours_utc;
   logic [5:0]  hours_sum;
   logic [5:0]  hours_loc;
   logic [5:0]  hours_ones;
   logic [3:0]  hours_tens;

   // FIN behaves like IDLE for acceptance so a start right after done is taken.
   assign accept = ((state_reg == IDLE) || (state_reg == FIN)) && start && gps_valid && !busy;

   // Per-character ASCII check and digit extraction (byte minus 8'h30).
   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_char
         logic [7:0] diff;
         assign diff        = byte_reg[gi] - 8'h30;
         assign dig[gi]     = diff[3:0];
         assign char_ok[gi] = (byte_reg[gi] >= 8'h30) && (byte_reg[gi] <= 8'h39);
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic: read six bytes, evaluate once, then report.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = READ;
         READ:    if (cnt_reg == 3'd6) state_next = CALC;
         CALC:    state_next = FIN;
         FIN:     state_next = accept ? READ : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Range checks and offset hour arithmetic; tens/ones by compare-subtract.
   always_comb begin
      hours_utc  = ({2'b00, dig[0]} << 3) + ({2'b00, dig[0]} << 1) + {2'b00, dig[1]};
      fields_ok  = (dig[0] <= 4'd2) && (hours_utc <= 6'd23) && (dig[2] <= 4'd5) &&
                   ((dig[4] <= 4'd5) || ((dig[4] == 4'd6) && (dig[5] == 4'd0)));
      conv_ok    = (&char_ok) && fields_ok;
      hours_sum  = hours_utc + OFFSET;
      hours_loc  = (hours_sum >= 6'd24) ? (hours_sum - 6'd24) : hours_sum;
      hours_tens = 4'd0;
      hours_ones = hours_loc;
      if (hours_loc >= 6'd20) begin
         hours_tens = 4'd2;
         hours_ones = hours_loc - 6'd20;
      end else if (hours_loc >= 6'd10) begin
         hours_tens = 4'd1;
         hours_ones = hours_loc - 6'd10;
      end
   end

   // Capture byte k two edges after its address was presented.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 6; k++) byte_reg[k] <= 8'h00;
      end else if (state_reg == READ) begin
         for (int k = 0; k < 6; k++)
            if (cnt_reg == 3'(k + 1)) byte_reg[k] <= rd_data;
      end
   end

   // Address sequencing, status pulses and digit outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr    <= ADDR_FIRST;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         cnt_reg    <= 3'd0;
         hh_t       <= 4'd0;
         hh_o       <= 4'd0;
         mm_t       <= 4'd0;
         mm_o       <= 4'd0;
         ss_t       <= 4'd0;
         ss_o       <= 4'd0;
         time_valid <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state_reg)
            IDLE, FIN: begin
               rd_addr <= ADDR_FIRST;
               if (accept) begin
                  busy    <= 1'b1;
                  cnt_reg <= 3'd0;
               end
            end
            READ: begin
               if (rd_addr != ADDR_LAST) rd_addr <= rd_addr + 6'd1;
               cnt_reg <= cnt_reg + 3'd1;
            end
            CALC: begin
               busy    <= 1'b0;
               rd_addr <= ADDR_FIRST;
               if (conv_ok) begin
                  hh_t       <= hours_tens;
                  hh_o       <= hours_ones[3:0];
                  mm_t       <= dig[2];
                  mm_o       <= dig[3];
                  ss_t       <= dig[4];
                  ss_o       <= dig[5];
                  time_valid <= 1'b1;
                  done       <= 1'b1;
               end else begin
                  time_valid <= 1'b0;
                  err        <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
